// File: rtl/fp_addsub_issuer.sv
// Initiator for the multi-cycle FP add/sub unit: accepts one request, pulses start,
// holds operands until done or timeout, then returns a response and accrues fflags.
module fp_addsub_issuer #(
  parameter int Size          = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_sub,
  input  logic [2:0]      req_rm,
  input  logic [4:0]      req_rd,
  input  logic [Size-1:0] req_operand_a,
  input  logic [Size-1:0] req_operand_b,
  input  logic [2:0]      frm,
  output logic            start,
  output logic            sub,
  output logic [2:0]      rounding_mode,
  output logic [Size-1:0] operand_a,
  output logic [Size-1:0] operand_b,
  input  logic [Size-1:0] result,
  input  logic            overflow,
  input  logic            underflow,
  input  logic            inexact,
  input  logic            invalid,
  input  logic            done,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [Size-1:0] resp_result,
  output logic [4:0]      resp_rd,
  output logic [4:0]      resp_flags,
  output logic            resp_illegal,
  output logic            resp_timeout,
  input  logic            fflags_clear,
  output logic [4:0]      fflags_accrued
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic [2:0]      rm_resolved;
  logic            rm_illegal;
  logic            resp_hs;

  assign rm_resolved = (req_rm == 3'b111) ? frm : req_rm;
  assign rm_illegal  = (rm_resolved >= 3'd5);
  assign cnt_inc     = cnt + CntW'(1);
  assign resp_hs     = (state == RESP) && resp_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = rm_illegal ? RESP : START;
      end
      START: begin
        start      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (done || (cnt_inc == CntMax)) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/op registers only reload on acceptance, so they stay held through WAIT and RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub           <= 1'b0;
      rounding_mode <= 3'b000;
      operand_a     <= '0;
      operand_b     <= '0;
      resp_result   <= '0;
      resp_rd       <= 5'd0;
      resp_flags    <= 5'd0;
      resp_illegal  <= 1'b0;
      resp_timeout  <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sub           <= req_sub;
            rounding_mode <= rm_resolved;
            operand_a     <= req_operand_a;
            operand_b     <= req_operand_b;
            resp_rd       <= req_rd;
            resp_illegal  <= rm_illegal;
            resp_timeout  <= 1'b0;
            resp_result   <= '0;
            resp_flags    <= 5'd0;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          if (done) begin
            resp_result <= result;
            resp_flags  <= {invalid, 1'b0, overflow, underflow, inexact};
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CntMax) resp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear takes priority, then the flags of a coincident handshake are ORed in.
  always_ff @(posedge clk) begin
    if (reset)             fflags_accrued <= 5'd0;
    else if (fflags_clear) fflags_accrued <= resp_hs ? resp_flags : 5'd0;
    else if (resp_hs)      fflags_accrued <= fflags_accrued | resp_flags;
  end

endmodule

// File: doc/fp_addsub_issuer.md
Name: fp_addsub_issuer

Overview:
- Initiator side of the multi-cycle FP add/sub start/done interface.
- Accepts one add/sub request per transaction from the integer/FP pipeline over a valid/ready handshake and resolves dynamic rounding mode against frm.
- Drives a single-cycle start pulse to the add/sub unit, holds its operands stable, waits for done, then captures result and exception flags.
- Returns a response over valid/ready and accumulates fflags for the CSR file.

Parameters:
- Size, 32, operand/result width.
- TimeoutCycles, 64, max cycles in WAIT before a timeout response; width of the counter is clog2(TimeoutCycles+1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  issuer can accept request.
- req_sub  input  1  1 = subtract.
- req_rm  input  3  instruction rounding mode; 3'b111 = dynamic.
- req_rd  input  5  destination register tag.
- req_operand_a  input  Size  operand A.
- req_operand_b  input  Size  operand B.
- frm  input  3  fcsr rounding mode.
- start  output  1  one-cycle start pulse to add/sub unit.
- sub  output  1  held operation to unit.
- rounding_mode  output  3  resolved mode to unit.
- operand_a  output  Size  held operand A to unit.
- operand_b  output  Size  held operand B to unit.
- result  input  Size  unit result.
- overflow  input  1  unit flag.
- underflow  input  1  unit flag.
- inexact  input  1  unit flag.
- invalid  input  1  unit flag.
- done  input  1  unit completion.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_result  output  Size  captured result.
- resp_rd  output  5  tag of the request.
- resp_flags  output  5  {NV,DZ,OF,UF,NX}; DZ always 0.
- resp_illegal  output  1  illegal rounding mode.
- resp_timeout  output  1  unit never signalled done.
- fflags_clear  input  1  clear accrued flags.
- fflags_accrued  output  5  sticky OR of all delivered resp_flags.

Behaviour:
- Reset (synchronous): state=IDLE. Outputs: req_ready=1, start=0, resp_valid=0, resp_illegal=0, resp_timeout=0, fflags_accrued=0. All data registers (sub, rounding_mode, operand_a, operand_b, resp_result, resp_rd, resp_flags) are 0. Reset mid-WAIT abandons the transaction; a late done after reset is ignored (IDLE ignores done).
- Rounding resolution: rm=3'b111 → use frm, otherwise use req_rm. Resolved value 3'b101, 3'b110 or 3'b111 is illegal.
- IDLE: req_ready=1. On req_valid, latch sub, resolved rm, operands and rd.
  - Legal rm → START.
  - Illegal rm → RESP with resp_illegal=1, resp_result=0, resp_flags=0, no start issued.
- START: start=1 for exactly this cycle; req_ready=0; clear timeout counter; → WAIT. done is ignored in START.
- WAIT: start=0; operand_a, operand_b, sub and rounding_mode stay held unchanged until leaving RESP.
  - On done=1: capture result into resp_result and resp_flags={invalid,0,overflow,underflow,inexact} → RESP.
  - Otherwise increment counter; on reaching TimeoutCycles → RESP with resp_timeout=1, resp_result=0, resp_flags=0.
- RESP: resp_valid=1; response fields stable while resp_ready=0.
  - On resp_ready: resp_valid drops next cycle; fflags_accrued |= resp_flags in the same edge → IDLE.
- Latency: request accepted in cycle T → start in T+1 → response visible the cycle after done is sampled. Minimum 3 cycles request-to-resp_valid.
- No back-to-back overlap: one outstanding transaction. req_ready=0 in START, WAIT and RESP.
- fflags_clear: clears accrued flags. If fflags_clear coincides with a response handshake, the result is resp_flags only (clear first, then OR).
- resp_illegal and resp_timeout are each cleared on entry to the next transaction. They never contribute to fflags_accrued.

Test Plan:
- Add 1.0+2.0 (0x3F800000, 0x40000000), rm=000, unit model done after 5 cycles with 0x40400000 and no flags → exactly one start pulse; resp_result=0x40400000; resp_flags=0; resp_valid 1 cycle after done.
- rm=111, frm=010, sub=1 → rounding_mode=010 and sub=1 held stable every WAIT cycle.
- Unit returns inexact=1, then on the next transaction overflow=1 → fflags_accrued=5'b00001, then 5'b00101. Assert fflags_clear on the second handshake → 5'b00100.
- rm=101, and separately rm=111 with frm=110 → no start; resp_illegal=1; fflags unchanged; req_ready back high after the handshake.
- done never asserted, TimeoutCycles=64 → resp_timeout=1 after 64 WAIT cycles; a later stray done in IDLE is ignored.
- Hold resp_ready=0 for 10 cycles, then pulse reset in WAIT → response held stable with req_ready=0 throughout; after reset all outputs return to reset values and a new request proceeds normally.
